// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state encoding and default UART frame width.
package uart_pkg;
   localparam int UART_WIDTH = 8;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector returning the first set request at or after ptr.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--)
         if (|(req & (N'(1) << ((int'(ptr) + k) % N)))) begin
            gnt = N'(1) << ((int'(ptr) + k) % N);
            idx = IW'((int'(ptr) + k) % N);
         end
   end
   assign any = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART tx core among NUM_REQ byte sources.
// Define UART_TX_ARB_TIMEOUT_EN to abort frames whose tx_done never arrives.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int WIDTH   = UART_WIDTH,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 200000
) (
   input  logic                     tx_clk,
   input  logic                     tx_rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     tx_en,
   output logic [WIDTH-1:0]         tx_data,
   input  logic                     tx_done,
   output logic                     busy,
   output logic [ID_W-1:0]          grant_id
`ifdef UART_TX_ARB_TIMEOUT_EN
   ,
   output logic                     tx_timeout
`endif
);
   logic [1:0] state;
   logic [ID_W-1:0] rr_ptr, pick;
   logic [NUM_REQ-1:0] gnt;
   logic any, idle, to_hit;

   if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT < 2) begin : g_bad_params
      $error("uart_tx_arbiter: illegal parameter set");
   end

   rr_picker #(.N(NUM_REQ), .IW(ID_W)) u_pick (
      .req(req_valid),
      .ptr(rr_ptr),
      .gnt(gnt),
      .idx(pick),
      .any(any)
   );

   assign idle = state == ST_IDLE;
   // Held requests must not see a handshake while the block sits in reset.
   assign req_ready = (idle && !tx_rst) ? gnt : '0;
   assign tx_en = state == ST_START;
   assign busy = !idle;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   assign to_hit = state == ST_WAIT && !tx_done && cnt == CW'(TIMEOUT - 1);
   assign tx_timeout = to_hit;
   always_ff @(posedge tx_clk or posedge tx_rst)
      if (tx_rst) cnt <= '0;
      else cnt <= (state == ST_WAIT) ? cnt + 1'b1 : '0;
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         state    <= ST_IDLE;
         tx_data  <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else if (idle) begin
         if (any) begin
            state    <= ST_START;
            tx_data  <= req_data[pick*WIDTH +: WIDTH];
            grant_id <= pick;
            rr_ptr   <= (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
         end
      end else if (state == ST_START) state <= ST_WAIT;
      else state <= (tx_done || to_hit || state != ST_WAIT) ? ST_IDLE : state;
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench with a transaction-level round-robin model.
// Build with UART_TX_ARB_TIMEOUT_EN to also exercise the frame-abort path.
module tb_uart_tx_arbiter;
   localparam int N = 4, W = 8, TO = 20;
   logic tx_clk = 1'b0;
   logic tx_rst, tx_en, tx_done, busy;
   logic [N-1:0] req_valid, req_ready;
   logic [N*W-1:0] req_data;
   logic [W-1:0] tx_data;
   logic [1:0] grant_id;
`ifdef UART_TX_ARB_TIMEOUT_EN
   logic tx_timeout;
`endif

   always #5 tx_clk = ~tx_clk;

   uart_tx_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
      .tx_clk(tx_clk),
      .tx_rst(tx_rst),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .tx_en(tx_en),
      .tx_data(tx_data),
      .tx_done(tx_done),
      .busy(busy),
      .grant_id(grant_id)
`ifdef UART_TX_ARB_TIMEOUT_EN
      ,
      .tx_timeout(tx_timeout)
`endif
   );

   typedef struct {int id; logic [W-1:0] d;} exp_t;
   exp_t sb[$];
   logic [W-1:0] q[N][$];
   int got_ids[$];
   logic [W-1:0] got_d[$];
   int tests = 0, fails = 0, to_seen = 0;
   bit m_free = 1, hold_all = 1, stall = 0, done_last = 0, exp_to = 0;
   int m_ptr = 0, wait_w = -1, frame_len = 0, acc_g = -1, fixed_len = 0;
   logic [N-1:0] exp_ready = '0;
   logic [W-1:0] last_d = '0;
   logic [1:0] last_id = '0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic int gid(int i);
      return i < got_ids.size() ? got_ids[i] : -1;
   endfunction

   function automatic bit pending();
      bit p = !m_free || sb.size() != 0 || acc_g >= 0;
      for (int i = 0; i < N; i++) p |= q[i].size() != 0;
      return p;
   endfunction

   // Applies the effect of the clock edge just taken, then drives this cycle's inputs.
   task automatic advance();
      if (done_last) begin
         m_free = 1;
         wait_w = -1;
         done_last = 0;
      end
      if (acc_g >= 0) begin
         void'(q[acc_g].pop_front());
         m_free = 0;
         wait_w = 0;
         frame_len = stall ? 1000 : fixed_len > 0 ? fixed_len : int'($urandom_range(1, 6));
         stall = 0;
         acc_g = -1;
      end else if (wait_w >= 0) wait_w++;
      exp_to = 0;
      if (wait_w >= 1 && wait_w == frame_len) begin
         tx_done = 1;
         done_last = 1;
      end
`ifdef UART_TX_ARB_TIMEOUT_EN
      else if (wait_w == TO) begin
         tx_done = 0;
         exp_to = 1;
         done_last = 1;
      end
`endif
      else tx_done = (wait_w <= 0) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
         req_valid[i] = q[i].size() > 0 && (hold_all || $urandom_range(0, 2) != 0);
         if (req_valid[i]) req_data[i*W +: W] = q[i][0];
         else req_data[i*W +: W] = W'($urandom);
      end
   endtask

   // Round-robin rule: first valid requester at or after the pointer, wrapping.
   task automatic predict();
      exp_ready = '0;
      if (m_free && |req_valid) begin
         for (int k = 0; k < N; k++) begin
            int c = (m_ptr + k) % N;
            if (req_valid[c]) begin
               acc_g = c;
               break;
            end
         end
         sb.push_back('{acc_g, q[acc_g][0]});
         exp_ready[acc_g] = 1'b1;
         m_ptr = (acc_g + 1) % N;
      end
   endtask

   task automatic step();
      @(posedge tx_clk);
      #1;
      advance();
      predict();
   endtask

   task automatic drain(int lim);
      int n = 0;
      while (pending() && n < lim) begin
         step();
         n++;
      end
      if (pending()) chk("drain_bound", 32'(n), 32'(lim + 1));
   endtask

   task automatic run_until_wait(int w, int lim);
      int n = 0;
      while (wait_w != w && n < lim) begin
         step();
         n++;
      end
      if (wait_w != w) chk("wait_bound", 32'(wait_w), 32'(w));
   endtask

   always @(negedge tx_clk) begin
      exp_t e;
      if (tx_rst) begin
         chk("reset_outputs", {req_ready, tx_en, busy, grant_id, tx_data}, 0);
         last_d = '0;
         last_id = '0;
      end else begin
         chk("req_ready", req_ready, exp_ready);
         chk("busy", busy, !m_free);
         chk("tx_en", tx_en, wait_w == 0);
`ifdef UART_TX_ARB_TIMEOUT_EN
         chk("tx_timeout", tx_timeout, exp_to);
         if (tx_timeout) to_seen++;
`endif
         if (tx_en) begin
            if (sb.size() == 0) chk("tx_en_unexpected", tx_en, 0);
            else begin
               e = sb.pop_front();
               chk("grant_id", grant_id, e.id);
               chk("tx_data", tx_data, e.d);
            end
            got_ids.push_back(int'(grant_id));
            got_d.push_back(tx_data);
            last_d = tx_data;
            last_id = grant_id;
         end else begin
            chk("tx_data_hold", tx_data, last_d);
            chk("grant_hold", grant_id, last_id);
         end
      end
   end

   initial begin
      logic [W-1:0] rr_exp[4];
      int base;
      rr_exp = '{8'h0a, 8'h24, 8'h33, 8'h14};
      tx_rst = 1;
      tx_done = 0;
      for (int i = 0; i < N; i++) begin
         q[i].push_back(rr_exp[i]);
         req_valid[i] = 1'b1;
         req_data[i*W +: W] = rr_exp[i];
      end
      #50;
      @(posedge tx_clk);
      #1;
      tx_rst = 0;
      predict();
      drain(400);
      for (int i = 0; i < 4; i++) begin
         chk("rr_order", 32'(gid(i)), 32'(i));
         chk("rr_data", i < got_d.size() ? got_d[i] : 'x, rr_exp[i]);
      end

      q[2].push_back(8'h0a);
      drain(100);
      chk("single_id", 32'(gid(got_ids.size() - 1)), 2);

      base = got_ids.size();
      for (int i = 0; i < 3; i++) q[1].push_back(8'h40 + 8'(i));
      run_until_wait(1, 50);
      q[3].push_back(8'h5c);
      drain(200);
      chk("fair_0", 32'(gid(base)), 1);
      chk("fair_1", 32'(gid(base + 1)), 3);
      chk("fair_2", 32'(gid(base + 2)), 1);

      hold_all = 0;
      repeat (400) begin
         if ($urandom_range(0, 2) == 0) begin
            int i = $urandom_range(0, N - 1);
            if (q[i].size() < 3) q[i].push_back(W'($urandom));
         end
         step();
      end
      hold_all = 1;
      drain(3000);

      fixed_len = 8;
      q[1].push_back(8'h77);
      q[2].push_back(8'h88);
      run_until_wait(2, 100);
      @(posedge tx_clk);
      #1;
      advance();
      tx_rst = 1;
      tx_done = 0;
      sb.delete();
      m_free = 1;
      m_ptr = 0;
      wait_w = -1;
      acc_g = -1;
      done_last = 0;
      exp_to = 0;
      exp_ready = '0;
      repeat (2) @(posedge tx_clk);
      #1;
      tx_rst = 0;
      predict();
      drain(200);
      fixed_len = 0;

`ifdef UART_TX_ARB_TIMEOUT_EN
      q[0].push_back(8'h55);
      q[1].push_back(8'h66);
      stall = 1;
      drain(300);
      chk("timeout_pulses", 32'(to_seen), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end
endmodule
